// File: rtl/branch_predict_ctrl.sv
// 2-bit saturating-counter branch predictor with ID-stage redirect and EX-stage mispredict recovery.
// Optional resolved/mispredict counters are built when BRPRED_STATS_EN is defined.
module branch_predict_ctrl #(
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iBranch_D,
  input  logic [ADDR_W-1:0] iPC_D,
  input  logic [ADDR_W-1:0] iTarget_D,
  input  logic              iStall_D,
  input  logic              iFlush_DE,
  input  logic              iTaken_E,
  output logic [1:0]        oBranch_predict,
  output logic              oRedirect,
  output logic [ADDR_W-1:0] oRedirectPC,
  output logic [31:0]       oBrCount,
  output logic [31:0]       oMissCount
);
  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]        pht [DEPTH];
  logic [IDX_W-1:0]  idx_D;
  logic              pred_D;
  logic              mispredict;

  logic              valid_E;
  logic              pred_E;
  logic [IDX_W-1:0]  idx_E;
  logic [ADDR_W-1:0] target_E;
  logic [ADDR_W-1:0] fall_E;

  assign idx_D      = iPC_D[IDX_W+1:2];
  assign pred_D     = iBranch_D & ~iStall_D & pht[idx_D][1];
  assign mispredict = valid_E & (pred_E != iTaken_E);

  // EX recovery outranks the ID prediction: the ID instruction is wrong-path then.
  always_comb begin
    oBranch_predict = 2'b00;
    oRedirect       = 1'b0;
    oRedirectPC     = '0;
    if (!rst) begin
      oBranch_predict = {mispredict, pred_D & ~mispredict};
      oRedirect       = mispredict | pred_D;
      if (mispredict)
        oRedirectPC = iTaken_E ? target_E : fall_E;
      else if (pred_D)
        oRedirectPC = iTarget_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_E  <= 1'b0;
      pred_E   <= 1'b0;
      idx_E    <= '0;
      target_E <= '0;
      fall_E   <= '0;
    end else begin
      valid_E  <= iBranch_D & ~iStall_D & ~iFlush_DE & ~mispredict;
      pred_E   <= pred_D;
      idx_E    <= idx_D;
      target_E <= iTarget_D;
      fall_E   <= iPC_D + ADDR_W'(4);
    end
  end

  // Training on every resolved branch; a same-cycle ID lookup sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pht[i] <= 2'd1;
    end else if (valid_E) begin
      if (iTaken_E && pht[idx_E] != 2'd3)
        pht[idx_E] <= pht[idx_E] + 2'd1;
      else if (!iTaken_E && pht[idx_E] != 2'd0)
        pht[idx_E] <= pht[idx_E] - 2'd1;
    end
  end

`ifdef BRPRED_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else begin
      if (valid_E)    br_cnt   <= br_cnt + 32'd1;
      if (mispredict) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign oBrCount   = br_cnt;
  assign oMissCount = miss_cnt;
`else
  assign oBrCount   = '0;
  assign oMissCount = '0;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: a behavioural predictor model pushes expected
// outputs per cycle; they are popped and compared at the falling edge.
module tb_branch_predict_ctrl;
  localparam int IDX_W  = 4;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              iBranch_D, iStall_D, iFlush_DE, iTaken_E;
  logic [ADDR_W-1:0] iPC_D, iTarget_D;
  logic [1:0]        oBranch_predict;
  logic              oRedirect;
  logic [ADDR_W-1:0] oRedirectPC;
  logic [31:0]       oBrCount, oMissCount;

  branch_predict_ctrl #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .iBranch_D(iBranch_D), .iPC_D(iPC_D), .iTarget_D(iTarget_D),
    .iStall_D(iStall_D), .iFlush_DE(iFlush_DE), .iTaken_E(iTaken_E),
    .oBranch_predict(oBranch_predict), .oRedirect(oRedirect), .oRedirectPC(oRedirectPC),
    .oBrCount(oBrCount), .oMissCount(oMissCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  bp;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] brc;
    logic [31:0] missc;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  // model state
  logic [1:0]  m_pht [16];
  logic        m_vE, m_pE;
  logic [3:0]  m_iE;
  logic [31:0] m_tE, m_fE, m_brc, m_miss;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_front(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "/empty"}, 64'd0, 64'd1);
      return;
    end
    e = q.pop_front();
    chk({tag, "/bp"},    64'(oBranch_predict), 64'(e.bp));
    chk({tag, "/redir"}, 64'(oRedirect),       64'(e.redir));
    chk({tag, "/rpc"},   64'(oRedirectPC),     64'(e.rpc));
    chk({tag, "/brc"},   64'(oBrCount),        64'(e.brc));
    chk({tag, "/miss"},  64'(oMissCount),      64'(e.missc));
  endtask

  function automatic exp_t cnt_exp(input exp_t e);
    exp_t r = e;
`ifdef BRPRED_STATS_EN
    r.brc = m_brc; r.missc = m_miss;
`else
    r.brc = 0; r.missc = 0;
`endif
    return r;
  endfunction

  // Hold reset for n cycles; outputs and counters must read zero.
  task automatic do_rst(input int n);
    exp_t e;
    rst = 1'b1;
    iBranch_D = 1'b1; iPC_D = 32'h40; iTarget_D = 32'h80;
    iStall_D = 1'b0; iFlush_DE = 1'b0; iTaken_E = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) m_pht[i] = 2'd1;
    m_vE = 0; m_pE = 0; m_iE = 0; m_tE = 0; m_fE = 0; m_brc = 0; m_miss = 0;
    for (int i = 0; i < n; i++) begin
      e.bp = 2'b00; e.redir = 1'b0; e.rpc = 0; e.brc = 0; e.missc = 0;
      q.push_back(e);
      @(negedge clk);
      compare_front("reset");
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  // One ID/EX cycle: drive, predict with the model, compare at negedge, advance model at edge.
  task automatic step(input string tag, input logic br, input logic [31:0] pc,
                      input logic [31:0] tgt, input logic stall, input logic flush,
                      input logic taken);
    exp_t e;
    logic mis, pred;
    logic [3:0] idx;
    iBranch_D = br; iPC_D = pc; iTarget_D = tgt;
    iStall_D = stall; iFlush_DE = flush; iTaken_E = taken;
    idx  = pc[5:2];
    mis  = m_vE & (m_pE != taken);
    pred = br & ~stall & m_pht[idx][1];
    e.bp    = {mis, pred & ~mis};
    e.redir = mis | pred;
    e.rpc   = mis ? (taken ? m_tE : m_fE) : (pred ? tgt : 32'd0);
    q.push_back(cnt_exp(e));
    @(negedge clk);
    compare_front(tag);
    @(posedge clk); #1;
    if (m_vE) begin
      m_brc++;
      if (taken && m_pht[m_iE] != 2'd3) m_pht[m_iE] = m_pht[m_iE] + 2'd1;
      if (!taken && m_pht[m_iE] != 2'd0) m_pht[m_iE] = m_pht[m_iE] - 2'd1;
    end
    if (mis) m_miss++;
    m_vE = br & ~stall & ~flush & ~mis;
    m_pE = pred; m_iE = idx; m_tE = tgt; m_fE = pc + 32'd4;
  endtask

  initial begin
    rst = 1'b1;
    do_rst(2);

    // cold branch: weak not-taken, then resolved taken -> mispredict to target
    step("cold_id",  1, 32'h40, 32'h80, 0, 0, 0);
    chk("cold_id_bp_const", 64'(oBranch_predict), 64'd0);
    step("cold_ex",  0, 32'h00, 32'h00, 0, 0, 1);
    // now weak taken: predicted, then not-taken -> recover to 0x44
    step("warm_id",  1, 32'h40, 32'h80, 0, 0, 0);
    step("warm_ex",  0, 32'h00, 32'h00, 0, 0, 0);

    // four taken in a row saturates, one not-taken leaves it predicting taken
    for (int i = 0; i < 4; i++) step("sat_run", 1, 32'h40, 32'h80, 0, 0, 1);
    step("sat_last", 0, 32'h00, 32'h00, 0, 0, 1);
    step("sat_nt_id", 1, 32'h40, 32'h80, 0, 0, 0);
    step("sat_nt_ex", 0, 32'h00, 32'h00, 0, 0, 0);
    step("sat_still", 1, 32'h40, 32'h80, 0, 0, 0);
    step("sat_drain", 0, 32'h00, 32'h00, 0, 0, 1);

    // EX mispredict (idx1, weak NT, taken) while a predicted-taken branch sits in ID
    step("pri_ex_setup", 1, 32'h44, 32'h200, 0, 0, 0);
    step("pri_collide",  1, 32'h40, 32'h80,  0, 0, 1);
    step("pri_bubble",   0, 32'h00, 32'h00,  0, 0, 0);

    // stall one cycle, then predict; then flushed branch never resolves
    step("stall_on",  1, 32'h40, 32'h90, 1, 0, 0);
    step("stall_off", 1, 32'h40, 32'h90, 0, 0, 1);
    step("stall_ex",  0, 32'h00, 32'h00, 0, 0, 1);
    step("flush_id",  1, 32'h40, 32'h90, 0, 1, 0);
    step("flush_ex",  0, 32'h00, 32'h00, 0, 0, 0);

    // random mix across a few indices, including wrap of PC+4
    for (int i = 0; i < 40; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : {26'd0, 4'($urandom_range(0, 3)), 2'b00};
      step("rand", 1'($urandom_range(0, 3) != 0), pc, $urandom,
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    // counters clear again on reset
    do_rst(1);
    step("post_rst", 1, 32'h40, 32'h80, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
